hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 54 +++++
 rtl/hazard_unit.sv | 177 +++++++++++++++++
 tb/tb_hazard_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared types and constants for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_unit_pkg;

    localparam int WORD_WIDTH         = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    // Slot rd storage width; instantiations may use any REG_ADDR_WIDTH up to this.
    localparam int RD_MAX_WIDTH       = 8;

    typedef struct packed {
        logic                    valid;
        logic [RD_MAX_WIDTH-1:0] rd;
        logic                    write_en;
        logic                    load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    function automatic logic slot_hits(
        input slot_t                   s,
        input logic [RD_MAX_WIDTH-1:0] rs,
        input logic                    use_rs
    );
        return s.valid && s.write_en && use_rs && (rs != '0) && (s.rd == rs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks destination info of the instructions in EX, MEM and WB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      clear,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_write_en,
    input  logic                      id_load,
    output slot_t                     ex_slot,
    output slot_t                     mem_slot,
    output slot_t                     wb_slot
);

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= SLOT_BUBBLE;
            r_mem <= SLOT_BUBBLE;
            r_wb  <= SLOT_BUBBLE;
        end else if (!stall) begin
            if (clear) begin
                r_ex <= SLOT_BUBBLE;
            end else begin
                r_ex <= '{valid:    1'b1,
                          rd:       RD_MAX_WIDTH'(id_rd),
                          write_en: id_write_en,
                          load:     id_load};
            end
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign ex_slot  = r_ex;
    assign mem_slot = r_mem;
    assign wb_slot  = r_wb;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard control: forwarding selects, load-use stall,
//               branch flush and memory freeze. Optional performance counters
//               are enabled by defining HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_use_rs1_i,
    input  logic                      id_use_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_write_en_i,
    input  logic                      id_load_i,
    input  logic                      branch_taken_i,
    input  logic                      mem_busy_i,
    output logic                      pc_stall_o,
    output logic                      if_id_stall_o,
    output logic                      if_id_clear_o,
    output logic                      id_ex_stall_o,
    output logic                      id_ex_clear_o,
    output logic                      fwrd_opA_type1_o,
    output logic                      fwrd_opA_type2_o,
    output logic                      fwrd_opB_type1_o,
    output logic                      fwrd_opB_type2_o,
    output logic [WORD_WIDTH-1:0]     stall_cnt_o,
    output logic [WORD_WIDTH-1:0]     flush_cnt_o
);

    state_t r_state;
    state_t r_saved_state;
    state_t w_next_state;
    state_t w_next_saved;
    state_t w_eff_state;

    slot_t w_ex_slot;
    slot_t w_mem_slot;
    slot_t w_wb_slot;

    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_clear;
    logic w_id_ex_stall;
    logic w_id_ex_clear;
    logic w_ex_rs1;
    logic w_ex_rs2;
    logic w_mem_rs1;
    logic w_mem_rs2;
    logic w_load_use;
    logic w_fwd_block;

    hazard_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .stall       (w_id_ex_stall),
        .clear       (w_id_ex_clear),
        .id_rd       (id_rd_i),
        .id_write_en (id_write_en_i),
        .id_load     (id_load_i),
        .ex_slot     (w_ex_slot),
        .mem_slot    (w_mem_slot),
        .wb_slot     (w_wb_slot)
    );

    // WB is tracked for pipeline bookkeeping only; no forwarding path uses it.
    logic w_unused_slot_bits;
    assign w_unused_slot_bits = &{1'b0, w_wb_slot, w_mem_slot.load};

    assign w_ex_rs1   = slot_hits(w_ex_slot,  RD_MAX_WIDTH'(id_rs1_i), id_use_rs1_i);
    assign w_ex_rs2   = slot_hits(w_ex_slot,  RD_MAX_WIDTH'(id_rs2_i), id_use_rs2_i);
    assign w_mem_rs1  = slot_hits(w_mem_slot, RD_MAX_WIDTH'(id_rs1_i), id_use_rs1_i);
    assign w_mem_rs2  = slot_hits(w_mem_slot, RD_MAX_WIDTH'(id_rs2_i), id_use_rs2_i);
    assign w_load_use = w_ex_slot.load && (w_ex_rs1 || w_ex_rs2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_saved_state <= RUN;
        end else begin
            r_state       <= w_next_state;
            r_saved_state <= w_next_saved;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_saved  = r_saved_state;
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_clear = 1'b0;
        w_id_ex_stall = 1'b0;
        w_id_ex_clear = 1'b0;
        // Leaving FREEZE behaves as the interrupted state in the same cycle.
        w_eff_state   = (r_state == FREEZE) ? r_saved_state : r_state;

        if (mem_busy_i) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_stall = 1'b1;
            w_next_state  = FREEZE;
            if (r_state != FREEZE) begin
                w_next_saved = r_state;
            end
        end else begin
            w_next_saved = RUN;
            case (w_eff_state)
                FLUSH: begin
                    w_if_id_clear = 1'b1;
                    w_next_state  = RUN;
                end
                default: begin
                    w_next_state = RUN;
                    if (branch_taken_i) begin
                        w_if_id_clear = 1'b1;
                        w_id_ex_clear = 1'b1;
                        w_next_state  = FLUSH;
                    end else if (w_load_use) begin
                        w_pc_stall    = 1'b1;
                        w_if_id_stall = 1'b1;
                        w_id_ex_clear = 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_fwd_block = rst || w_id_ex_stall || w_id_ex_clear;

    assign pc_stall_o       = w_pc_stall    && !rst;
    assign if_id_stall_o    = w_if_id_stall && !rst;
    assign if_id_clear_o    = w_if_id_clear && !rst;
    assign id_ex_stall_o    = w_id_ex_stall && !rst;
    assign id_ex_clear_o    = w_id_ex_clear && !rst;
    assign fwrd_opA_type1_o = w_ex_rs1 && !w_ex_slot.load && !w_fwd_block;
    assign fwrd_opB_type1_o = w_ex_rs2 && !w_ex_slot.load && !w_fwd_block;
    assign fwrd_opA_type2_o = w_mem_rs1 && !w_ex_rs1 && !w_fwd_block;
    assign fwrd_opB_type2_o = w_mem_rs2 && !w_ex_rs2 && !w_fwd_block;

`ifdef HAZARD_PERF_CNT_EN
    logic [WORD_WIDTH-1:0] r_stall_cnt;
    logic [WORD_WIDTH-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall_o) begin
                r_stall_cnt <= r_stall_cnt + WORD_WIDTH'(1);
            end
            if (if_id_clear_o) begin
                r_flush_cnt <= r_flush_cnt + WORD_WIDTH'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed self-checking bench for hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       br;
        logic       busy;
        logic [8:0] exp;
    } vec_t;

    // {pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear, A1, A2, B1, B2}
    localparam logic [8:0] E_NONE = 9'h000;
    localparam logic [8:0] E_A1   = 9'h008;
    localparam logic [8:0] E_A2   = 9'h004;
    localparam logic [8:0] E_B1   = 9'h002;
    localparam logic [8:0] E_B2   = 9'h001;
    localparam logic [8:0] E_LU   = 9'h190;
    localparam logic [8:0] E_BR   = 9'h050;
    localparam logic [8:0] E_FL   = 9'h040;
    localparam logic [8:0] E_FRZ  = 9'h1A0;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_write_en, id_load;
    logic        branch_taken, mem_busy;
    logic        pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear;
    logic        fA1, fA2, fB1, fB2;
    logic [31:0] stall_cnt, flush_cnt;
    logic [8:0]  act;

    int checks = 0;
    int errors = 0;
    int m_stall = 0;
    int m_flush = 0;

    vec_t vecs [10];

    always #5 clk = ~clk;

    assign act = {pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear, fA1, fA2, fB1, fB2};

    hazard_unit #(
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_use_rs1_i     (id_use_rs1),
        .id_use_rs2_i     (id_use_rs2),
        .id_rd_i          (id_rd),
        .id_write_en_i    (id_write_en),
        .id_load_i        (id_load),
        .branch_taken_i   (branch_taken),
        .mem_busy_i       (mem_busy),
        .pc_stall_o       (pc_stall),
        .if_id_stall_o    (if_id_stall),
        .if_id_clear_o    (if_id_clear),
        .id_ex_stall_o    (id_ex_stall),
        .id_ex_clear_o    (id_ex_clear),
        .fwrd_opA_type1_o (fA1),
        .fwrd_opA_type2_o (fA2),
        .fwrd_opB_type1_o (fB1),
        .fwrd_opB_type2_o (fB2),
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
    );

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic we, input logic ld, input logic br,
                                input logic busy, input logic [8:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.we = we; v.ld = ld; v.br = br; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        id_rd = v.rd; id_write_en = v.we; id_load = v.ld;
        branch_taken = v.br; mem_busy = v.busy;
    endtask

    // Called just after a rising edge; checks mid-cycle, returns just after the next edge.
    task automatic run_cycle(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        check(name, 32'(act), 32'(v.exp));
        m_stall += int'(v.exp[8]);
        m_flush += int'(v.exp[6]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = mk( 1,  2, 1, 1,  5, 1, 0, 0, 0, E_NONE);
        vecs[1] = mk( 5,  3, 1, 1,  6, 1, 0, 0, 0, E_A1);
        vecs[2] = mk( 6,  5, 1, 1,  8, 1, 0, 0, 0, E_A1 | E_B2);
        vecs[3] = mk( 8,  8, 1, 1,  0, 1, 0, 0, 0, E_A1 | E_B1);
        vecs[4] = mk( 0,  0, 1, 1,  9, 0, 0, 0, 0, E_NONE);
        vecs[5] = mk( 9,  0, 1, 1,  7, 1, 1, 0, 0, E_NONE);
        vecs[6] = mk( 1,  7, 1, 1, 10, 1, 0, 0, 0, E_LU);
        vecs[7] = mk( 1,  7, 1, 1, 10, 1, 0, 0, 0, E_B2);
        vecs[8] = mk(10, 10, 0, 1,  0, 0, 0, 0, 0, E_B1);
        vecs[9] = mk(10,  0, 0, 1,  0, 0, 0, 0, 0, E_NONE);

        // Reset holds every output low even with hazards on the inputs.
        rst = 1'b1;
        drive(mk(5, 5, 1, 1, 5, 1, 1, 1, 1, E_NONE));
        #2;
        check("reset_outputs", 32'(act), 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_cycle(vecs[i], $sformatf("vec%0d", i));
        end
        check("table_stall_cnt", stall_cnt, cnt_exp(m_stall));
        check("table_flush_cnt", flush_cnt, cnt_exp(m_flush));

        // Branch and load-use together: flush wins, no stall.
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 7, 1, 1, 0, 0, E_NONE), "brlu_lw");
        run_cycle(mk(7, 0, 1, 0, 3, 1, 0, 1, 0, E_BR),   "brlu_branch");
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL),   "brlu_flush");
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), "brlu_run");
        check("brlu_flush_cnt", flush_cnt, cnt_exp(2));
        check("brlu_stall_cnt", stall_cnt, cnt_exp(0));

        // Freeze for three cycles in the middle of a flush.
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, E_NONE), "frz_add");
        run_cycle(mk(0, 0, 0, 0, 6, 1, 0, 1, 0, E_BR),   "frz_branch");
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(5, 0, 1, 0, 0, 0, 0, 0, 1, E_FRZ), $sformatf("frz_busy%0d", i));
        end
        run_cycle(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, E_FL | E_A2), "frz_release");
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE),      "frz_run");
        check("frz_stall_cnt", stall_cnt, cnt_exp(3));
        check("frz_flush_cnt", flush_cnt, cnt_exp(2));

        // Asynchronous reset while frozen.
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZ), "arst_enter");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ));
        @(negedge clk);
        check("arst_frozen", 32'(act), 32'(E_FRZ));
        rst = 1'b1;
        #1;
        check("arst_outputs", 32'(act), 32'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_stall = 0;
        m_flush = 0;
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), "arst_run");

        // Reset during FLUSH leaves no pending flush.
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_BR), "rflush_branch");
        rst = 1'b1;
        #2;
        check("rflush_outputs", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), "rflush_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
